fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : single-outstanding instruction fetch FSM feeding the IF/ID reg.
// Optional macro FETCH_MISALIGN_TRAP_EN adds fetch_fault_o (misaligned trap).
// Revision   : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid_if_id;
    } if_id_reg_t;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fetch_fault_o,
`endif
    output if_id_reg_t  out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    // Holds a response that arrived while out was full and stalled.
    logic        buf_valid_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_instr_q;

    logic [31:0] pc_inc;
    logic [31:0] redir_pc;
    logic        consume;
    logic        has_room;
    logic        bad_redirect;
    logic        halted;

    assign pc_inc      = fetch_pc_q + 32'd4;
    assign consume     = out.valid_if_id & ~stall_i;
    assign has_room    = ~out.valid_if_id | consume;
    assign imem_req_o  = (state_q == REQ);
    assign imem_addr_o = fetch_pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    assign redir_pc      = redirect_pc_i;
    assign bad_redirect  = |redirect_pc_i[1:0];
    assign halted        = fault_q;
    assign fetch_fault_o = fault_q;
`else
    assign redir_pc      = redirect_pc_i & 32'hFFFF_FFFC;
    assign bad_redirect  = 1'b0;
    assign halted        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            fetch_pc_q      <= RESET_PC;
            buf_valid_q     <= 1'b0;
            buf_pc_q        <= RESET_PC;
            buf_instr_q     <= NOP_INSTR;
            out.pc          <= RESET_PC;
            out.instruction <= NOP_INSTR;
            out.pc_plus4    <= RESET_PC + 32'd4;
            out.valid_if_id <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q         <= 1'b0;
`endif
        end else begin
            if (consume) begin
                out.valid_if_id <= 1'b0;
                out.instruction <= NOP_INSTR;
            end
            if (redirect_i) begin
                out.valid_if_id <= 1'b0;
                out.instruction <= NOP_INSTR;
                buf_valid_q     <= 1'b0;
                fetch_pc_q      <= redir_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                fault_q         <= bad_redirect;
`endif
                if (bad_redirect) begin
                    state_q <= IDLE;
                end else begin
                    // A grant or pending response still owes one discard.
                    case (state_q)
                        REQ:     state_q <= imem_gnt_i ? DRAIN : REQ;
                        WAIT:    state_q <= (buf_valid_q | imem_rvalid_i) ? REQ : DRAIN;
                        DRAIN:   state_q <= imem_rvalid_i ? REQ : DRAIN;
                        default: state_q <= REQ;
                    endcase
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!halted) state_q <= REQ;
                    end
                    REQ: begin
                        if (imem_gnt_i) state_q <= WAIT;
                    end
                    WAIT: begin
                        if (buf_valid_q) begin
                            if (consume) begin
                                out.pc          <= buf_pc_q;
                                out.instruction <= buf_instr_q;
                                out.pc_plus4    <= buf_pc_q + 32'd4;
                                out.valid_if_id <= 1'b1;
                                buf_valid_q     <= 1'b0;
                                state_q         <= REQ;
                            end
                        end else if (imem_rvalid_i) begin
                            fetch_pc_q <= pc_inc;
                            if (has_room) begin
                                out.pc          <= fetch_pc_q;
                                out.instruction <= imem_rdata_i;
                                out.pc_plus4    <= pc_inc;
                                out.valid_if_id <= 1'b1;
                                state_q         <= REQ;
                            end else begin
                                buf_valid_q <= 1'b1;
                                buf_pc_q    <= fetch_pc_q;
                                buf_instr_q <= imem_rdata_i;
                            end
                        end
                    end
                    DRAIN: begin
                        if (imem_rvalid_i) state_q <= REQ;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed + randomized self-checking bench for fetch_unit.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    if_id_reg_t  out;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault_o;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_fault_o (fetch_fault_o),
`endif
        .out           (out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          delivered = 0;
    // memory responder state
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_dly = 0;
    int          gnt_pct = 100;
    int          dly_min = 0;
    int          dly_max = 0;
    bit          last_g = 1'b0;
    logic [31:0] last_gaddr = '0;
    int          gcyc [logic [31:0]];
    // reference model: the pc the next delivered instruction must carry
    logic [31:0] exp_pc = RESET_PC;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic do_reset(input bit clear_mem);
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        @(posedge clk); #1; cyc++;
        reset = 1'b0;
        exp_pc = RESET_PC;
        if (clear_mem) pend = 1'b0;
    endtask

    // One clock: drive inputs, check the stream against the model, advance.
    task automatic step(input bit stall, input bit redir, input logic [31:0] tgt);
        bit          g, rv;
        logic [31:0] a;
        if_id_reg_t  prev_out;
        bit          prev_req;
        g  = imem_req_o && !pend && ($urandom_range(99) < gnt_pct);
        rv = pend && (pend_dly == 0);
        a  = imem_addr_o;
        stall_i = stall; redirect_i = redir; redirect_pc_i = tgt;
        imem_gnt_i = g; imem_rvalid_i = rv;
        imem_rdata_i = rv ? instr_of(pend_addr) : $urandom;
        if (out.valid_if_id) begin
            checks++;
            if (out.pc !== exp_pc) $display("FAIL stream_pc: got %h want %h", out.pc, exp_pc);
            else passes++;
            checks++;
            if (out.instruction !== instr_of(exp_pc))
                $display("FAIL stream_instr: got %h want %h", out.instruction, instr_of(exp_pc));
            else passes++;
            checks++;
            if (out.pc_plus4 !== exp_pc + 32'd4)
                $display("FAIL stream_pc_plus4: got %h want %h", out.pc_plus4, exp_pc + 32'd4);
            else passes++;
        end else begin
            checks++;
            if (out.instruction !== NOP) $display("FAIL invalid_nop: got %h want %h", out.instruction, NOP);
            else passes++;
        end
        if (imem_req_o) begin
            checks++;
            if (a[1:0] !== 2'b00) $display("FAIL addr_align: got %h want low bits 00", a);
            else passes++;
        end
        prev_out = out;
        prev_req = imem_req_o;
        if (out.valid_if_id && !stall) begin
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (redir) exp_pc = eff_target(tgt);
        @(posedge clk); #1; cyc++;
        if (rv) pend = 1'b0;
        else if (pend) pend_dly--;
        if (g) begin
            pend = 1'b1; pend_addr = a;
            pend_dly = $urandom_range(dly_max, dly_min);
            gcyc[a] = cyc - 1;
        end
        last_g = g; last_gaddr = a;
        if (prev_out.valid_if_id && stall && !redir) begin
            checks++;
            if (out !== prev_out) $display("FAIL stall_hold: got %h want %h", out, prev_out);
            else passes++;
        end
        if (prev_req && !g && !redir) begin
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== a)
                $display("FAIL req_stable: got req=%b addr=%h want req=1 addr=%h", imem_req_o, imem_addr_o, a);
            else passes++;
        end
    endtask

    task automatic test_reset();
        gnt_pct = 0;
        do_reset(1'b1);
        checks++;
        if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req_o); else passes++;
        checks++;
        if (out.valid_if_id !== 1'b0) $display("FAIL reset_valid: got %b want 0", out.valid_if_id); else passes++;
        checks++;
        if (out.instruction !== NOP) $display("FAIL reset_instr: got %h want %h", out.instruction, NOP); else passes++;
        checks++;
        if (out.pc !== RESET_PC) $display("FAIL reset_pc: got %h want %h", out.pc, RESET_PC); else passes++;
        checks++;
        if (out.pc_plus4 !== RESET_PC + 32'd4)
            $display("FAIL reset_pc_plus4: got %h want %h", out.pc_plus4, RESET_PC + 32'd4);
        else passes++;
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++;
        if (fetch_fault_o !== 1'b0) $display("FAIL reset_fault: got %b want 0", fetch_fault_o); else passes++;
`endif
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC)
            $display("FAIL idle_to_req: got req=%b addr=%h want req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC);
        else passes++;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_sequential();
        logic [31:0] gq[$];
        logic [31:0] oq[$];
        logic [31:0] p4q[$];
        int          latq[$];
        logic [31:0] e;
        do_reset(1'b1);
        gnt_pct = 100; dly_min = 0; dly_max = 0;
        for (int i = 0; i < 30 && oq.size() < 3; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (last_g) gq.push_back(last_gaddr);
            if (out.valid_if_id) begin
                oq.push_back(out.pc);
                p4q.push_back(out.pc_plus4);
                latq.push_back(cyc - gcyc[out.pc]);
            end
        end
        checks++;
        if (oq.size() != 3) $display("FAIL seq_count: got %0d want 3", oq.size()); else passes++;
        for (int i = 0; i < oq.size(); i++) begin
            e = RESET_PC + 32'(4 * i);
            checks++;
            if (i >= gq.size() || gq[i] !== e) $display("FAIL seq_addr: index %0d want %h", i, e);
            else passes++;
            checks++;
            if (oq[i] !== e) $display("FAIL seq_out_pc: got %h want %h", oq[i], e); else passes++;
            checks++;
            if (p4q[i] !== e + 32'd4) $display("FAIL seq_pc_plus4: got %h want %h", p4q[i], e + 32'd4); else passes++;
            checks++;
            if (latq[i] != 2) $display("FAIL seq_latency: got %0d want 2", latq[i]); else passes++;
        end
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        do_reset(1'b1);
        gnt_pct = 100; dly_min = 0; dly_max = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (out.valid_if_id && out.pc == 32'h8) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) $display("FAIL stall_setup: got %b want 1", found); else passes++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            checks++;
            if (out.valid_if_id !== 1'b1 || out.pc !== 32'h8)
                $display("FAIL stall_out: got valid=%b pc=%h want valid=1 pc=00000008", out.valid_if_id, out.pc);
            else passes++;
            if (i > 0) begin
                checks++;
                if (imem_req_o !== 1'b0) $display("FAIL stall_req: got %b want 0", imem_req_o); else passes++;
            end
        end
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (out.valid_if_id !== 1'b1 || out.pc !== 32'hC)
            $display("FAIL stall_release_out: got valid=%b pc=%h want valid=1 pc=0000000c", out.valid_if_id, out.pc);
        else passes++;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10)
            $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=00000010", imem_req_o, imem_addr_o);
        else passes++;
    endtask

    task automatic test_redirect_wait();
        bit found = 1'b0;
        do_reset(1'b1);
        gnt_pct = 100; dly_min = 2; dly_max = 2;
        for (int i = 0; i < 10 && !last_g; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (last_g) begin
                found = 1'b1;
                checks++;
                if (last_gaddr !== 32'h100) $display("FAIL redir_wait_addr: got %h want 00000100", last_gaddr);
                else passes++;
            end else begin
                checks++;
                if (out.valid_if_id !== 1'b0) $display("FAIL redir_wait_discard: got %b want 0", out.valid_if_id);
                else passes++;
            end
        end
        checks++;
        if (found !== 1'b1) $display("FAIL redir_wait_timeout: got %b want 1", found); else passes++;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_redirect_rvalid_stall();
        do_reset(1'b1);
        gnt_pct = 100; dly_min = 0; dly_max = 0;
        for (int i = 0; i < 10 && !out.valid_if_id; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h200);
        checks++;
        if (out.valid_if_id !== 1'b0 || out.instruction !== NOP)
            $display("FAIL redir_rv_out: got valid=%b instr=%h want valid=0 instr=%h", out.valid_if_id, out.instruction, NOP);
        else passes++;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200)
            $display("FAIL redir_rv_addr: got req=%b addr=%h want req=1 addr=00000200", imem_req_o, imem_addr_o);
        else passes++;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        logic [31:0] gq[$];
        bit          seen = 1'b0;
        do_reset(1'b1);
        gnt_pct = 0;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        gnt_pct = 100; dly_min = 0; dly_max = 0;
        for (int i = 0; i < 20 && (gq.size() < 2 || !seen); i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (last_g) gq.push_back(last_gaddr);
            if (out.valid_if_id && out.pc == 32'hFFFF_FFFC && !seen) begin
                seen = 1'b1;
                checks++;
                if (out.pc_plus4 !== 32'h0) $display("FAIL wrap_pc_plus4: got %h want 00000000", out.pc_plus4);
                else passes++;
            end
        end
        checks++;
        if (gq.size() < 2 || gq[0] !== 32'hFFFF_FFFC || gq[1] !== 32'h0)
            $display("FAIL wrap_addrs: got %0d grants, want fffffffc then 00000000", gq.size());
        else passes++;
        checks++;
        if (seen !== 1'b1) $display("FAIL wrap_out: got %b want 1", seen); else passes++;
    endtask

    task automatic test_misalign();
        do_reset(1'b1);
        gnt_pct = 0;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fetch_fault_o !== 1'b1 || imem_req_o !== 1'b0)
                $display("FAIL trap_hold: got fault=%b req=%b want fault=1 req=0", fetch_fault_o, imem_req_o);
            else passes++;
            step(1'b0, 1'b0, 32'h0);
        end
        step(1'b0, 1'b1, 32'h104);
        checks++;
        if (fetch_fault_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h104)
            $display("FAIL trap_clear: got fault=%b req=%b addr=%h want 0 1 00000104", fetch_fault_o, imem_req_o, imem_addr_o);
        else passes++;
`else
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100)
            $display("FAIL misalign_force: got req=%b addr=%h want req=1 addr=00000100", imem_req_o, imem_addr_o);
        else passes++;
`endif
    endtask

    task automatic test_late_rvalid();
        int grants = 0;
        bit seen = 1'b0;
        do_reset(1'b1);
        gnt_pct = 100; dly_min = 3; dly_max = 3;
        for (int i = 0; i < 20 && grants < 2; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (last_g) grants++;
        end
        do_reset(1'b0);
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (out.valid_if_id) begin
                seen = 1'b1;
                checks++;
                if (out.pc !== RESET_PC || out.instruction !== instr_of(RESET_PC))
                    $display("FAIL late_rvalid: got pc=%h instr=%h want pc=%h instr=%h",
                             out.pc, out.instruction, RESET_PC, instr_of(RESET_PC));
                else passes++;
            end
        end
        checks++;
        if (seen !== 1'b1) $display("FAIL late_rvalid_timeout: got %b want 1", seen); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] t;
        do_reset(1'b1);
        delivered = 0;
        gnt_pct = 70; dly_min = 0; dly_max = 3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(999) < 5) begin
                do_reset(1'b0);
            end else begin
                t = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                             : 32'($urandom_range(1023));
`ifdef FETCH_MISALIGN_TRAP_EN
                t = t & 32'hFFFF_FFFC;
`endif
                step($urandom_range(99) < 30, $urandom_range(99) < 4, t);
            end
        end
        checks++;
        if (delivered < 80) $display("FAIL random_progress: got %0d want >= 80", delivered); else passes++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid_stall();
        test_wrap();
        test_misalign();
        test_late_rvalid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
